// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Owns the register-file write port. It clears every register
//                after reset, then arbitrates the ALU and load writeback
//                requesters. Defining WB_BYPASS_EN adds combinational read
//                forwarding ports.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int FAIR   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_writeRegister,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              init_done,
    output logic              grant_mem
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
`endif
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_last_grant_mem;
    logic              w_alu_first;

    // Round-robin favours the requester that did not win last time.
    always_comb begin
        w_alu_first = (FAIR != 0) ? r_last_grant_mem : 1'b1;
        alu_ready   = (r_state == ST_ARB) && alu_valid && (!mem_valid || w_alu_first);
        mem_ready   = (r_state == ST_ARB) && mem_valid && (!alu_valid || !w_alu_first);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_CLEAR;
            r_clr_cnt        <= '0;
            r_last_grant_mem <= 1'b1;
            rf_regwrite      <= 1'b0;
            rf_writeRegister <= '0;
            rf_writeData     <= '0;
            init_done        <= 1'b0;
            grant_mem        <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // Counter MSB sets once all NUM_REGS entries have been written.
                    if (r_clr_cnt[ADDR_W]) begin
                        r_state     <= ST_ARB;
                        init_done   <= 1'b1;
                        rf_regwrite <= 1'b0;
                    end else begin
                        rf_regwrite      <= 1'b1;
                        rf_writeRegister <= r_clr_cnt[ADDR_W-1:0];
                        rf_writeData     <= '0;
                        grant_mem        <= 1'b0;
                        r_clr_cnt        <= r_clr_cnt + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (alu_ready) begin
                        rf_regwrite      <= (alu_addr != '0);
                        rf_writeRegister <= alu_addr;
                        rf_writeData     <= alu_data;
                        grant_mem        <= 1'b0;
                        r_last_grant_mem <= 1'b0;
                    end else if (mem_ready) begin
                        rf_regwrite      <= (mem_addr != '0);
                        rf_writeRegister <= mem_addr;
                        rf_writeData     <= mem_data;
                        grant_mem        <= 1'b1;
                        r_last_grant_mem <= 1'b1;
                    end else begin
                        rf_regwrite <= 1'b0;
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rd_data1 = (rf_regwrite && rf_writeRegister == rd_addr1 && rd_addr1 != '0)
                   ? rf_writeData : rf_rdata1;
        rd_data2 = (rf_regwrite && rf_writeRegister == rd_addr2 && rd_addr2 != '0)
                   ? rf_writeData : rf_rdata2;
    end
`endif

    logic w_unused;
    assign w_unused = (NUM_REGS == 0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Bench for regfile_wb_arbiter; a round-robin and a fixed
//                priority instance share one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;

    logic        ar1, mr1, we1, id1, gm1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ar0, mr0, we0, id0, gm0;
    logic [4:0]  wa0;
    logic [31:0] wd0;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FAIR(1)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(ar1), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mr1), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_regwrite(we1), .rf_writeRegister(wa1), .rf_writeData(wd1),
        .init_done(id1), .grant_mem(gm1)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FAIR(0)) dut0 (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(ar0), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mr0), .mem_addr(mem_addr), .mem_data(mem_data),
        .rf_regwrite(we0), .rf_writeRegister(wa0), .rf_writeData(wd0),
        .init_done(id0), .grant_mem(gm0)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ar1;
        logic        mr1;
        logic        ar0;
        logic        mr0;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        gm;
    } wr_t;

    wr_t  q1[$];
    wr_t  q0[$];
    vec_t v[13];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input wr_t e, input logic we,
                            input logic [4:0] a, input logic [31:0] d, input logic gm);
        check({name, "_we"}, 64'(we), 64'(e.we));
        if (e.we) begin
            check({name, "_addr"}, 64'(a), 64'(e.addr));
            check({name, "_data"}, 64'(d), 64'(e.data));
            check({name, "_gm"}, 64'(gm), 64'(e.gm));
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic e_ar1, input logic e_mr1,
                                input logic e_ar0, input logic e_mr0);
        vec_t r;
        r.av = av; r.aa = aa; r.ad = ad;
        r.mv = mv; r.ma = ma; r.md = md;
        r.ar1 = e_ar1; r.mr1 = e_mr1; r.ar0 = e_ar0; r.mr0 = e_mr0;
        return r;
    endfunction

    function automatic wr_t expect_wr(input vec_t x, input logic a_win, input logic m_win);
        wr_t w;
        w.we = 1'b0; w.addr = '0; w.data = '0; w.gm = 1'b0;
        if (a_win) begin
            w.we = (x.aa != 5'd0); w.addr = x.aa; w.data = x.ad; w.gm = 1'b0;
        end else if (m_win) begin
            w.we = (x.ma != 5'd0); w.addr = x.ma; w.data = x.md; w.gm = 1'b1;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wr_t e;

        // Round-robin instance starts with ALU as last winner after the r5 write.
        v[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
        v[1]  = mk(1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b1, 1'b1, 1'b0);
        v[2]  = mk(1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h23,       1'b1, 1'b0, 1'b1, 1'b0);
        v[3]  = mk(1'b1, 5'd3, 32'h12,       1'b1, 5'd4, 32'h23,       1'b0, 1'b1, 1'b1, 1'b0);
        v[4]  = mk(1'b1, 5'd3, 32'h12,       1'b1, 5'd4, 32'h24,       1'b1, 1'b0, 1'b1, 1'b0);
        v[5]  = mk(1'b1, 5'd3, 32'h13,       1'b1, 5'd4, 32'h24,       1'b0, 1'b1, 1'b1, 1'b0);
        v[6]  = mk(1'b1, 5'd3, 32'h13,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
        v[7]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b1, 1'b0, 1'b1);
        v[8]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        v[9]  = mk(1'b1, 5'd0, 32'h1234,     1'b1, 5'd6, 32'h66,       1'b1, 1'b0, 1'b1, 1'b0);
        v[10] = mk(1'b1, 5'd9, 32'h99,       1'b1, 5'd6, 32'h66,       1'b0, 1'b1, 1'b1, 1'b0);
        v[11] = mk(1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
        v[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0);

        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_we", 64'(we1), 64'd0);
        check("rst_init", 64'(id1), 64'd0);
        check("rst_ready", 64'({ar1, mr1}), 64'd0);
        check("rst_addr_data_gm", 64'({wa1, wd1, gm1}), 64'd0);
        check("rst_we_fixed", 64'(we0), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(posedge clock);
            #1;
            check("clr_we", 64'(we1), 64'd1);
            check("clr_addr", 64'(wa1), 64'(i));
            check("clr_data", 64'(wd1), 64'd0);
            check("clr_hold", 64'({id1, ar1, mr1}), 64'd0);
        end

        @(posedge clock);
        #1;
        check("init_done", 64'(id1), 64'd1);
        check("init_we", 64'(we1), 64'd0);
        check("init_alu_ready", 64'({ar1, mr1}), 64'b10);

        @(posedge clock);
        #1;
        e.we = 1'b1; e.addr = 5'd5; e.data = 32'hDEADBEEF; e.gm = 1'b0;
        check_wr("held_alu", e, we1, wa1, wd1, gm1);

        for (int i = 0; i < 13; i++) begin
            alu_valid = v[i].av; alu_addr = v[i].aa; alu_data = v[i].ad;
            mem_valid = v[i].mv; mem_addr = v[i].ma; mem_data = v[i].md;
            #1;
            check($sformatf("row%0d_rdy_rr", i), 64'({ar1, mr1}), 64'({v[i].ar1, v[i].mr1}));
            check($sformatf("row%0d_rdy_fix", i), 64'({ar0, mr0}), 64'({v[i].ar0, v[i].mr0}));
            q1.push_back(expect_wr(v[i], v[i].ar1, v[i].mr1));
            q0.push_back(expect_wr(v[i], v[i].ar0, v[i].mr0));
            @(posedge clock);
            #1;
            e = q1.pop_front();
            check_wr($sformatf("row%0d_wr_rr", i), e, we1, wa1, wd1, gm1);
            e = q0.pop_front();
            check_wr($sformatf("row%0d_wr_fix", i), e, we0, wa0, wd0, gm0);
        end

        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h55;
        @(posedge clock);
        #1;
        e.we = 1'b1; e.addr = 5'd9; e.data = 32'h55; e.gm = 1'b0;
        check_wr("pre_rst_r9", e, we1, wa1, wd1, gm1);
        reset = 1'b1;
        alu_valid = 1'b0;
        #1;
        check("midrst_we", 64'({we1, we0}), 64'd0);
        check("midrst_init", 64'({id1, ar1}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            e.we = 1'b1; e.addr = 5'(i); e.data = 32'h0; e.gm = 1'b0;
            check_wr($sformatf("reclr%0d", i), e, we1, wa1, wd1, gm1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
